// File: rtl/latency_tracker_pkg.sv
// latency_tracker_pkg: shared widths and parameter range limits for the
// latency_tracker issue/retire tracker and its tag delay line.
package latency_tracker_pkg;

  // Width of the inflight counter port (covers 0..MAX_LATENCY).
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned MAX_LATENCY = 63;

  // Legal parameter ranges, checked at elaboration.
  localparam int unsigned MIN_LATENCY  = 1;
  localparam int unsigned MIN_TAG_W    = 1;
  localparam int unsigned MAX_TAG_W    = 16;
  localparam int unsigned MIN_INFLIGHT = 1;

endpackage

// File: rtl/tag_delay_line.sv
// tag_delay_line: enable-gated shift register of {valid, tag} pairs.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   enable             advances every stage by one when high, holds when low
//   in_valid, in_tag   loaded into stage 0; tag forced to zero when invalid
//   out_valid, out_tag last stage (DEPTH-1), registered
module tag_delay_line #(
  parameter int unsigned DEPTH = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  // Shift stages; empty slots carry a zero tag so done_tag reads 0 when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i] <= '0;
      end
    end else if (enable) begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= in_valid ? in_tag : '0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/latency_tracker.sv
// latency_tracker: tracks up to MAX_INFLIGHT overlapping fixed-latency
// operations; each retires LATENCY_CYCLES enabled cycles after issue.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   enable                 pipeline advance; low freezes all state
//   issue_valid, issue_tag operation request and its tag
//   issue_ready            combinational credit/enable qualified ready
//   done, done_tag         oldest operation at the pipeline output
//   inflight, busy         outstanding operation count and non-zero flag
//   err_overflow           sticky dropped-issue flag, present only when
//                          LATENCY_TRACKER_ERR_EN is defined
module latency_tracker
  import latency_tracker_pkg::*;
#(
  parameter int unsigned LATENCY_CYCLES = 23,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned MAX_INFLIGHT   = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  output logic             done,
  output logic [TAG_W-1:0] done_tag,
  output logic [CNT_W-1:0] inflight,
  output logic             busy
`ifdef LATENCY_TRACKER_ERR_EN
  ,
  output logic             err_overflow
`endif
);

  // Elaboration-time parameter range checks.
  if (LATENCY_CYCLES < MIN_LATENCY || LATENCY_CYCLES > MAX_LATENCY) begin : g_bad_latency
    $error("latency_tracker: LATENCY_CYCLES out of range 1..63");
  end
  if (TAG_W < MIN_TAG_W || TAG_W > MAX_TAG_W) begin : g_bad_tag_w
    $error("latency_tracker: TAG_W out of range 1..16");
  end
  if (MAX_INFLIGHT < MIN_INFLIGHT || MAX_INFLIGHT > LATENCY_CYCLES) begin : g_bad_inflight
    $error("latency_tracker: MAX_INFLIGHT out of range 1..LATENCY_CYCLES");
  end

  logic             accept_c;
  logic             retire_c;
  logic [CNT_W-1:0] inflight_d;

  // A retiring op frees its credit on the same edge, so the limit can be refilled.
  assign retire_c    = enable & done;
  assign issue_ready = enable & ((inflight < CNT_W'(MAX_INFLIGHT)) | retire_c);
  assign accept_c    = issue_valid & issue_ready;

  tag_delay_line #(
    .DEPTH (LATENCY_CYCLES),
    .TAG_W (TAG_W)
  ) u_line (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (accept_c),
    .in_tag    (issue_tag),
    .out_valid (done),
    .out_tag   (done_tag)
  );

  // Credit counter next value; simultaneous accept and retire cancel.
  always_comb begin
    inflight_d = inflight;
    if (accept_c && !retire_c) begin
      inflight_d = inflight + CNT_W'(1);
    end else if (retire_c && !accept_c) begin
      inflight_d = inflight - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      busy     <= 1'b0;
    end else begin
      inflight <= inflight_d;
      busy     <= (inflight_d != '0);
    end
  end

`ifdef LATENCY_TRACKER_ERR_EN
  // Sticky flag for an issue request refused while the pipeline advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow <= 1'b0;
    end else if (issue_valid && enable && !issue_ready) begin
      err_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/latency_tracker.md
# latency_tracker

Parametrised issue/retire tracker for fixed-latency pipelined arithmetic cores in the softmax datapath (exp, divider, accumulator IP). It generalises the single-shot latency counter: up to MAX_INFLIGHT overlapping operations are tracked, each tagged, each retired exactly LATENCY_CYCLES enabled cycles after issue, with stall support and back-pressure. It sits beside each vendor IP core, driven by the stage controller, and produces the valid/tag stream that downstream stages consume.

## Interface
- LATENCY_CYCLES, 23, enabled cycles from issue to retire; legal range 1..63
- TAG_W, 4, width of the tag carried with each operation; legal range 1..16
- MAX_INFLIGHT, 23, credit limit on outstanding operations; legal range 1..LATENCY_CYCLES
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  pipeline advance; low freezes all state (mirrors the IP core's clock enable)
- issue_valid  in  1  request to start an operation this cycle
- issue_tag  in  TAG_W  tag of the issued operation
- issue_ready  out  1  operation accepted on this edge if issue_valid also high
- done  out  1  oldest tracked operation has reached the pipeline output
- done_tag  out  TAG_W  tag of that operation; valid only while done=1
- inflight  out  6  number of tracked operations, 0..MAX_INFLIGHT
- busy  out  1  inflight != 0

## Operation
- Internal state: valid/tag delay line, stages 0..LATENCY_CYCLES-1, plus inflight counter. done = valid[LATENCY_CYCLES-1], done_tag = tag[LATENCY_CYCLES-1], both registered.
- accept = issue_valid & issue_ready. retire = enable & done.
- issue_ready = enable & ((inflight < MAX_INFLIGHT) | retire). This is combinational. A retire and an accept on the same edge is legal at the credit limit.
- On an edge with enable=1, every stage shifts by one. Stage 0 loads {accept, issue_tag}. The tag in stage 0 is zeroed when accept=0.
- inflight update: +1 on accept only, -1 on retire only, unchanged on both or neither. It never exceeds MAX_INFLIGHT and never underflows.
- enable=0: no shift, no accept (issue_ready=0), no retire. done and done_tag hold their values. Consumers qualify with enable.
- Reset: all stage valids and tags = 0, inflight = 0, done = 0, done_tag = 0, busy = 0. In-flight operations are discarded with no retire pulse.

## Timing
- Latency: an op accepted on enabled edge E0 shows done=1 in the cycle after the LATENCY_CYCLES-th enabled edge, counting E0 as the first. With LATENCY_CYCLES=1, done is high the cycle after acceptance.
- Stall cycles add one cycle each to the wall-clock latency and zero to the enabled-cycle latency.
- Back-to-back issues on consecutive enabled edges retire on consecutive enabled edges, in order, with tags preserved.
- issue_ready has a combinational path from enable, done and inflight. It has no path from issue_valid.

## Configuration
- LATENCY_TRACKER_ERR_EN defined: adds output `err_overflow` (1 bit, sticky). It is set on any edge with issue_valid=1, enable=1 and issue_ready=0, and cleared only by reset. Reset value is 0.
- LATENCY_TRACKER_ERR_EN undefined: the port and its logic are absent, and a dropped issue is silent.

## Structure
- Package latency_tracker_pkg holds:
  - CNT_W = 6
  - MAX_LATENCY = 63
  - range-check constants, used by elaboration-time assertions on the three parameters
- One sub-module, tag_delay_line: a generic enable-gated shift register of {valid, tag}, parameterised by DEPTH and TAG_W. The top contains the credit counter, ready logic and error flag.

## Test plan
- LATENCY_CYCLES=23, a single issue with tag 5 and enable held high → done=1 with done_tag=5 exactly 23 cycles after acceptance, then inflight returns 0 and busy drops.
- 23 consecutive issues with tags 0..22 (wrapping mod 16) → issue_ready stays high, inflight peaks at 23, and the tags retire in order on consecutive cycles.
- MAX_INFLIGHT=4, issue every cycle → issue_ready low on the 5th request until the first retire. Same-edge accept plus retire keeps inflight at 4.
- Issue, then drop enable for 10 cycles mid-flight → done is delayed by exactly 10 cycles. done held high across a stall does not decrement inflight.
- reset asserted with 7 ops in flight → next cycle done=0, inflight=0, busy=0. No stale done appears afterward.
- With LATENCY_TRACKER_ERR_EN, issue at the credit limit with no retire → err_overflow=1 and stays set until reset. inflight is unchanged.
